// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module : regfile_wb_arbiter
// Brief  : Round-robin arbiter sharing the regfile write port between the ALU
//          and load writeback paths, with pending-write hazard queries.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] q_addr1,
  output logic              q_hit1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              q_hit2
);

  logic              last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              grant0, grant1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // last_grant_q == 1 means requester 0 has priority on the next contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_comb begin
    win_addr     = grant1 ? req1_addr : req0_addr;
    win_data     = grant1 ? req1_data : req0_data;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (grant0 || grant1) begin
      last_grant_d = grant1;
      // x0 beats are accepted and steer last_grant but never write the regfile.
      rf_we_d      = (win_addr != '0);
      rf_waddr_d   = win_addr;
      rf_wdata_d   = win_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    if (!rst) begin
      q_hit1 = (q_addr1 != '0) &&
               ((rf_we_q && (rf_waddr_q == q_addr1)) ||
                (req0_valid && (req0_addr == q_addr1)) ||
                (req1_valid && (req1_addr == q_addr1)));
      q_hit2 = (q_addr2 != '0) &&
               ((rf_we_q && (rf_waddr_q == q_addr2)) ||
                (req0_valid && (req0_addr == q_addr2)) ||
                (req1_valid && (req1_addr == q_addr2)));
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module : tb_regfile_wb_arbiter
// Brief  : Directed self-checking bench for regfile_wb_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] q_addr1, q_addr2;
  logic              q_hit1, q_hit2;

  logic [DATA_W-1:0] regs [32];

  int n_checks = 0;
  int n_fails  = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .q_addr1    (q_addr1),
    .q_hit1     (q_hit1),
    .q_addr2    (q_addr2),
    .q_hit2     (q_hit2)
  );

  always #5 clk = ~clk;

  // Behavioural regfile fed by the DUT write port.
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    q_addr1 = '0; q_addr2 = '0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #2;
    chk("rst_rf_we",    {63'd0, rf_we}, 64'd0);
    chk("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_rf_wdata", {32'd0, rf_wdata}, 64'd0);
    q_addr1 = 5'd5;
    drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2);
    chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
    chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
    chk("rst_qhit1",  {63'd0, q_hit1}, 64'd0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    q_addr1 = '0;
    step();
    rst = 1'b0;
    step();

    // Reset mid-operation: beat to x3 accepted, then rst before its write edge.
    drive(1'b1, 5'd3, 32'h33, 1'b0, '0, '0);
    chk("mid_ready0", {63'd0, req0_ready}, 64'd1);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("mid_we_pre",    {63'd0, rf_we}, 64'd1);
    chk("mid_waddr_pre", {59'd0, rf_waddr}, 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_we_async",    {63'd0, rf_we}, 64'd0);
    chk("mid_waddr_async", {59'd0, rf_waddr}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_regs3", {32'd0, regs[3]}, 64'd0);

    // Contention for 4 cycles: 0,1,0,1 starting with requester 0.
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    chk("con_c0_r0", {63'd0, req0_ready}, 64'd1);
    chk("con_c0_r1", {63'd0, req1_ready}, 64'd0);
    step();
    chk("con_c1_r0", {63'd0, req0_ready}, 64'd0);
    chk("con_c1_r1", {63'd0, req1_ready}, 64'd1);
    chk("con_c1_we", {63'd0, rf_we}, 64'd1);
    chk("con_c1_wa", {59'd0, rf_waddr}, 64'd1);
    chk("con_c1_wd", {32'd0, rf_wdata}, 64'h11);
    step();
    chk("con_c2_r0", {63'd0, req0_ready}, 64'd1);
    chk("con_c2_we", {63'd0, rf_we}, 64'd1);
    chk("con_c2_wa", {59'd0, rf_waddr}, 64'd2);
    chk("con_c2_wd", {32'd0, rf_wdata}, 64'h22);
    step();
    chk("con_c3_r1", {63'd0, req1_ready}, 64'd1);
    chk("con_c3_we", {63'd0, rf_we}, 64'd1);
    chk("con_c3_wa", {59'd0, rf_waddr}, 64'd1);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("con_c4_we", {63'd0, rf_we}, 64'd1);
    chk("con_c4_wa", {59'd0, rf_waddr}, 64'd2);
    step();
    chk("con_c5_we", {63'd0, rf_we}, 64'd0);
    chk("con_regs1", {32'd0, regs[1]}, 64'h11);
    chk("con_regs2", {32'd0, regs[2]}, 64'h22);

    // Single requester.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    chk("one_ready0", {63'd0, req0_ready}, 64'd1);
    chk("one_ready1", {63'd0, req1_ready}, 64'd0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("one_we", {63'd0, rf_we}, 64'd1);
    chk("one_wa", {59'd0, rf_waddr}, 64'd5);
    chk("one_wd", {32'd0, rf_wdata}, 64'hDEADBEEF);
    chk("one_ready0_drop", {63'd0, req0_ready}, 64'd0);
    step();
    chk("one_we_off",  {63'd0, rf_we}, 64'd0);
    chk("one_wa_hold", {59'd0, rf_waddr}, 64'd5);
    chk("one_regs5",   {32'd0, regs[5]}, 64'hDEADBEEF);

    // x0 drop on requester 1, then contention must favour requester 0.
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
    chk("x0_ready1", {63'd0, req1_ready}, 64'd1);
    step();
    drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
    chk("x0_we",     {63'd0, rf_we}, 64'd0);
    chk("x0_wd",     {32'd0, rf_wdata}, 64'hFFFFFFFF);
    chk("x0_con_r0", {63'd0, req0_ready}, 64'd1);
    chk("x0_con_r1", {63'd0, req1_ready}, 64'd0);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
    chk("x0_after_we", {63'd0, rf_we}, 64'd1);
    chk("x0_regs0",    {32'd0, regs[0]}, 64'd0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);

    // Hazard query: req1 to x7 stalled behind a req0 grant.
    q_addr1 = 5'd7; q_addr2 = 5'd0;
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'h77);
    chk("hz_a_r0",   {63'd0, req0_ready}, 64'd1);
    chk("hz_a_r1",   {63'd0, req1_ready}, 64'd0);
    chk("hz_a_hit1", {63'd0, q_hit1}, 64'd1);
    chk("hz_a_hit2", {63'd0, q_hit2}, 64'd0);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h77);
    chk("hz_b_r1",   {63'd0, req1_ready}, 64'd1);
    chk("hz_b_wa",   {59'd0, rf_waddr}, 64'd4);
    chk("hz_b_hit1", {63'd0, q_hit1}, 64'd1);
    chk("hz_b_hit2", {63'd0, q_hit2}, 64'd0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("hz_c_we",   {63'd0, rf_we}, 64'd1);
    chk("hz_c_wa",   {59'd0, rf_waddr}, 64'd7);
    chk("hz_c_hit1", {63'd0, q_hit1}, 64'd1);
    chk("hz_c_hit2", {63'd0, q_hit2}, 64'd0);
    step();
    chk("hz_d_we",   {63'd0, rf_we}, 64'd0);
    chk("hz_d_hit1", {63'd0, q_hit1}, 64'd0);
    chk("hz_d_hit2", {63'd0, q_hit2}, 64'd0);
    chk("hz_regs7",  {32'd0, regs[7]}, 64'h77);
    chk("hz_regs4",  {32'd0, regs[4]}, 64'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
